// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and {Z,N,C,V} flags.
// Define ALU_SEQ_MULDIV_EN to build the iterative MULLO/MULHI/DIVU datapath.
module alu_seq #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [3:0]       select,
  input  logic [SHW-1:0]   rotate,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  localparam int M = WIDTH - 1;

  localparam logic [1:0] IDLE = 2'd0;
`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [1:0] EXEC = 2'd1;
`endif
  localparam logic [1:0] EVAL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, out_q;
  logic [3:0]       op_q, flags_q;
  logic [SHW-1:0]   rot_q;

  logic [WIDTH-1:0] b_op, res;
  logic [WIDTH:0]   sum_add, sum_sub, shl, shr;
  logic [SHW:0]     inv;
  logic             c_d, v_d;
  logic [3:0]       flags_d;

`ifdef ALU_SEQ_MULDIV_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_init;
  logic [SHW-1:0]     cnt_q;
  logic [WIDTH:0]     part, rsh, diff;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign flags     = flags_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EVAL;
`ifdef ALU_SEQ_MULDIV_EN
          if (select >= 4'd13) state_d = EXEC;
`endif
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      EXEC: if (cnt_q == SHW'(WIDTH - 1)) state_d = EVAL;
`endif
      EVAL: state_d = DONE;
      default: if (out_ready) state_d = IDLE;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  // Low half holds multiplier bits (mul) or dividend/quotient bits (div).
  always_comb begin
    acc_init = {{WIDTH{1'b0}}, (select == 4'd15) ? in0 : in1};
    part = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
         + (acc_q[0] ? {1'b0, a_q} : '0);
    rsh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[M]};
    diff = rsh - {1'b0, b_q};
    if (op_q == 4'd15) begin
      if (diff[WIDTH])
        acc_d = {rsh[M:0], acc_q[M-1:0], 1'b0};
      else
        acc_d = {diff[M:0], acc_q[M-1:0], 1'b1};
    end else begin
      acc_d = {part, acc_q[M:1]};
    end
  end
`endif

  always_comb begin
    b_op = b_q;
    if (op_q == 4'd7 || op_q == 4'd8) b_op = WIDTH'(1);
    sum_add = {1'b0, a_q} + {1'b0, b_op};
    sum_sub = {1'b0, a_q} - {1'b0, b_op};
    shl = {1'b0, a_q} << rot_q;
    shr = {a_q, 1'b0} >> rot_q;
    inv = (SHW + 1)'(WIDTH) - {1'b0, rot_q};
    res = '0;
    c_d = 1'b0;
    v_d = 1'b0;
    case (op_q)
      4'd0: res = a_q;
      4'd1: res = a_q & b_q;
      4'd2: res = a_q | b_q;
      4'd3: res = a_q ^ b_q;
      4'd4: res = ~a_q;
      4'd5, 4'd7: begin
        res = sum_add[M:0];
        c_d = sum_add[WIDTH];
        v_d = (a_q[M] == b_op[M]) && (res[M] != a_q[M]);
      end
      4'd6, 4'd8: begin
        res = sum_sub[M:0];
        c_d = sum_sub[WIDTH];
        v_d = (a_q[M] != b_op[M]) && (res[M] != a_q[M]);
      end
      4'd9: begin
        res = shl[M:0];
        c_d = shl[WIDTH];
      end
      4'd10: begin
        res = shr[WIDTH:1];
        c_d = shr[0];
      end
      4'd11: res = (a_q << rot_q) | (a_q >> inv);
      4'd12: res = (a_q >> rot_q) | (a_q << inv);
`ifdef ALU_SEQ_MULDIV_EN
      4'd13: begin
        res = acc_q[M:0];
        c_d = |acc_q[2*WIDTH-1:WIDTH];
        v_d = c_d;
      end
      4'd14: res = acc_q[2*WIDTH-1:WIDTH];
      4'd15: begin
        if (b_q == '0) begin
          res = '1;
          c_d = 1'b1;
        end else begin
          res = acc_q[M:0];
        end
      end
`endif
      // Unsupported multi-cycle ops report zero with carry set.
      default: begin
        res = '0;
        c_d = 1'b1;
      end
    endcase
    flags_d = {(res == '0), res[M], c_d, v_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rot_q   <= '0;
      out_q   <= '0;
      flags_q <= '0;
`ifdef ALU_SEQ_MULDIV_EN
      acc_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        a_q   <= in0;
        b_q   <= in1;
        op_q  <= select;
        rot_q <= rotate;
`ifdef ALU_SEQ_MULDIV_EN
        acc_q <= acc_init;
        cnt_q <= '0;
`endif
      end
`ifdef ALU_SEQ_MULDIV_EN
      if (state_q == EXEC) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + SHW'(1);
      end
`endif
      if (state_q == EVAL) begin
        out_q   <= res;
        flags_q <= flags_d;
      end
    end
  end

endmodule
